// File: rtl/sim_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sim_run_ctrl_if
//  Description : Bundles the run controller's core-facing signals. The core
//                (or its harness) reports err/halt; the controller returns
//                the core reset, run flag, cycle count and terminal status.
//
//  Signals     : err          core error indication (core -> controller)
//                halt         core halt indication  (core -> controller)
//                core_rst     active-high reset to the core
//                run          high while the core is running
//                cycle_count  number of RUN cycles completed
//                done         high in any terminal state
//                status       00 none, 01 halted, 10 error, 11 timeout
//
//  Modports    : master - the run controller
//                slave  - the core / harness side
//
//  Revision    : 1.0 - initial release
// ============================================================================
interface sim_run_ctrl_if #(
    parameter int CNT_W = 32
) ();

    logic             err;
    logic             halt;
    logic             core_rst;
    logic             run;
    logic [CNT_W-1:0] cycle_count;
    logic             done;
    logic [1:0]       status;

    modport master (
        input  err,
        input  halt,
        output core_rst,
        output run,
        output cycle_count,
        output done,
        output status
    );

    modport slave (
        output err,
        output halt,
        input  core_rst,
        input  run,
        input  cycle_count,
        input  done,
        input  status
    );

endinterface : sim_run_ctrl_if
`default_nettype wire

// File: rtl/sim_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sim_run_ctrl
//  Description : Run controller for the processor top level. Holds the core
//                in reset for RST_CYCLES cycles after system reset releases,
//                counts RUN cycles, latches the first error/halt indication,
//                enforces a MAX_CYCLES watchdog and reports a single
//                done/status pair.
//
//  Parameters  : RST_CYCLES  cycles core_rst stays high after rst releases
//                            (>= 1)
//                MAX_CYCLES  watchdog limit on RUN-state cycles
//                CNT_W       width of the cycle and hold counters; must hold
//                            MAX_CYCLES+1 and RST_CYCLES
//
//  Ports       : clk   system clock, rising-edge active
//                rst   synchronous reset, active-low
//                bus   sim_run_ctrl_if master modport
//                      (err, halt in; core_rst, run, cycle_count, done,
//                       status out)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_run_ctrl #(
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 100004,
    parameter int CNT_W      = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    sim_run_ctrl_if.master bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX       = CNT_W'(MAX_CYCLES);

    localparam logic [1:0] C_ST_NONE    = 2'b00;
    localparam logic [1:0] C_ST_HALTED  = 2'b01;
    localparam logic [1:0] C_ST_ERROR   = 2'b10;
    localparam logic [1:0] C_ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RUN     = 3'd1,
        S_HALTED  = 3'd2,
        S_ERROR   = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             r_core_rst;
    logic             r_run;
    logic             r_done;
    logic [1:0]       r_status;

    // Every output is a flop, so err/halt never reach an output
    // combinationally; each transition below sets the output values that
    // belong to the destination state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_core_rst  <= 1'b1;
            r_run       <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= C_ST_NONE;
        end else begin
            case (r_state)
                S_HOLD: begin
                    // err/halt are deliberately not looked at while the core
                    // is still held in reset.
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (r_hold_cnt == C_HOLD_LAST) begin
                        r_state    <= S_RUN;
                        r_core_rst <= 1'b0;
                        r_run      <= 1'b1;
                    end
                end

                S_RUN: begin
                    // The count advances on the leaving edge as well, so a
                    // terminal cycle_count includes the cycle that ended RUN.
                    r_cycle_cnt <= r_cycle_cnt + 1'b1;
                    if (bus.err) begin
                        r_state    <= S_ERROR;
                        r_core_rst <= 1'b1;
                        r_run      <= 1'b0;
                        r_done     <= 1'b1;
                        r_status   <= C_ST_ERROR;
                    end else if (bus.halt) begin
                        r_state    <= S_HALTED;
                        r_core_rst <= 1'b1;
                        r_run      <= 1'b0;
                        r_done     <= 1'b1;
                        r_status   <= C_ST_HALTED;
                    end else if (r_cycle_cnt >= C_MAX) begin
                        // Pre-increment count c >= MAX is the same test as
                        // c+1 > MAX without needing an extra counter bit.
                        r_state    <= S_TIMEOUT;
                        r_core_rst <= 1'b1;
                        r_run      <= 1'b0;
                        r_done     <= 1'b1;
                        r_status   <= C_ST_TIMEOUT;
                    end
                end

                S_HALTED, S_ERROR, S_TIMEOUT: begin
                    // Terminal: everything frozen until rst is asserted.
                    r_state <= r_state;
                end

                default: begin
                    // Unreachable encodings recover to a safe terminal-free
                    // hold with the core in reset.
                    r_state     <= S_HOLD;
                    r_hold_cnt  <= '0;
                    r_cycle_cnt <= '0;
                    r_core_rst  <= 1'b1;
                    r_run       <= 1'b0;
                    r_done      <= 1'b0;
                    r_status    <= C_ST_NONE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.core_rst    = r_core_rst;
    assign bus.run         = r_run;
    assign bus.cycle_count = r_cycle_cnt;
    assign bus.done        = r_done;
    assign bus.status      = r_status;

endmodule : sim_run_ctrl
`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_run_ctrl
//  Description : Self-checking bench for sim_run_ctrl. Directed scenarios for
//                reset release, halt, error priority, watchdog, mid-run
//                reset and HOLD masking, followed by randomized episodes.
//                All outputs are compared every cycle against a behavioural
//                model.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_run_ctrl;

    localparam int RST_CYCLES = 2;
    localparam int MAX_CYCLES = 20;
    localparam int CNT_W      = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    sim_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

    sim_run_ctrl #(
        .RST_CYCLES (RST_CYCLES),
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model:
    //   m_since - edges seen with rst high since the last reset (saturating
    //             once the core is released)
    //   m_cnt   - RUN cycles completed
    //   m_term  - terminal result code (0 none, 1 halted, 2 error, 3 timeout)
    int m_since = 0;
    int m_cnt   = 0;
    int m_term  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit h);
        if (!r) begin
            m_since = 0;
            m_cnt   = 0;
            m_term  = 0;
        end else if (m_term == 0) begin
            if (m_since < RST_CYCLES) begin
                m_since++;
            end else begin
                m_cnt++;
                if (e)                     m_term = 2;
                else if (h)                m_term = 1;
                else if (m_cnt > MAX_CYCLES) m_term = 3;
            end
        end
    endtask

    task automatic compare_all();
        bit running;
        running = (m_term == 0) && (m_since >= RST_CYCLES);
        check_eq("core_rst",    32'(bus.core_rst), 32'(!running));
        check_eq("run",         32'(bus.run),      32'(running));
        check_eq("done",        32'(bus.done),     32'(m_term != 0));
        check_eq("status",      32'(bus.status),   32'(m_term));
        check_eq("cycle_count", bus.cycle_count,   32'(m_cnt));
    endtask

    // One clock: drive inputs away from the edge, update the model with the
    // values sampled at the edge, then compare shortly after it.
    task automatic step(input bit r, input bit e, input bit h);
        rst      = r;
        bus.err  = e;
        bus.halt = h;
        @(posedge clk);
        model_edge(r, e, h);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Run quietly until the model's cycle count reaches n (bounded).
    task automatic run_until(input int n);
        int guard;
        guard = 0;
        while (m_cnt < n && m_term == 0 && guard < 200) begin
            step(1'b1, 1'b0, 1'b0);
            guard++;
        end
        if (m_cnt != n) begin
            checks++;
            failures++;
            $display("FAIL run_until: reached=%0d wanted=%0d", m_cnt, n);
        end
    endtask

    initial begin
        bus.err  = 1'b0;
        bus.halt = 1'b0;
        #2;

        // Reset release: core_rst for exactly RST_CYCLES edges after release.
        do_reset(3);
        step(1'b1, 1'b0, 1'b0);
        check_eq("rel_edge0_core_rst", 32'(bus.core_rst), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check_eq("rel_edge1_run", 32'(bus.run), 32'd1);
        check_eq("rel_edge1_cnt", bus.cycle_count, 32'd0);

        // Halt at count 10; a later err pulse must not change status.
        run_until(10);
        step(1'b1, 1'b0, 1'b1);
        check_eq("halt_status", 32'(bus.status), 32'd1);
        check_eq("halt_count",  bus.cycle_count, 32'd11);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_eq("halt_sticky", 32'(bus.status), 32'd1);

        // err and halt together: error wins.
        do_reset(2);
        run_until(5);
        step(1'b1, 1'b1, 1'b1);
        check_eq("prio_status", 32'(bus.status), 32'd2);
        check_eq("prio_count",  bus.cycle_count, 32'd6);

        // Watchdog.
        do_reset(1);
        run_until(MAX_CYCLES);
        step(1'b1, 1'b0, 1'b0);
        check_eq("wd_status", 32'(bus.status), 32'd3);
        check_eq("wd_count",  bus.cycle_count, 32'(MAX_CYCLES + 1));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        check_eq("wd_frozen", bus.cycle_count, 32'(MAX_CYCLES + 1));

        // Mid-run reset, then the sequence repeats.
        do_reset(1);
        run_until(7);
        step(1'b0, 1'b0, 1'b0);
        check_eq("midrst_cnt",  bus.cycle_count, 32'd0);
        check_eq("midrst_crst", 32'(bus.core_rst), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_eq("rerun_run", 32'(bus.run), 32'd1);
        run_until(7);

        // HOLD masking: err/halt high throughout HOLD are ignored.
        do_reset(2);
        for (int i = 0; i < RST_CYCLES; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_eq("mask_run",  32'(bus.run),  32'd1);
        check_eq("mask_done", 32'(bus.done), 32'd0);

        // Randomized episodes.
        for (int ep = 0; ep < 40; ep++) begin
            int len;
            do_reset(int'($urandom_range(1, 3)));
            len = int'($urandom_range(1, 45));
            for (int i = 0; i < len; i++) begin
                bit r, e, h;
                r = ($urandom_range(0, 59) != 0);
                e = ($urandom_range(0, 24) == 0);
                h = ($urandom_range(0, 24) == 0);
                step(r, e, h);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sim_run_ctrl
`default_nettype wire
